// File: rtl/clk_sup_pkg.sv
// Shared encodings and widths for the PLL/MMCM lock supervisor.
package clk_sup_pkg;
  localparam int STATE_W = 3;
  localparam int RETRY_W = 8;
  localparam int LOSS_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RELEASE    = 3'd3,
    RUN        = 3'd4,
    FAIL       = 3'd5
  } state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction
endpackage

// File: rtl/clk_sup_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear; output lags d by two edges.
module clk_sup_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/clk_lock_supervisor.sv
// PLL/MMCM reset and lock sequencer with staggered downstream reset release.
// Optional lock-loss event counter output enabled by CLK_SUP_LOSS_CNT_EN.
module clk_lock_supervisor
  import clk_sup_pkg::*;
#(
  parameter int NUM_OUT          = 3,
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STAGGER_CYC      = 8,
  parameter int MAX_RETRY        = 4
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               locked,
  input  logic               retry_req,
  output logic               pll_rst,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               all_ready,
  output logic               fail,
  output logic [STATE_W-1:0] state_o,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef CLK_SUP_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]  loss_cnt
`endif
);
  localparam int CNT_W = $clog2(max4(RST_PULSE_CYC, LOCK_STABLE_CYC,
                                     LOCK_TIMEOUT_CYC, STAGGER_CYC)) + 1;
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [NUM_OUT-1:0] ALL_ON       = {NUM_OUT{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  logic               rst_n;
  logic               lock_s;
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_OUT-1:0] mask, mask_nxt;
  logic [RETRY_W-1:0] retry_nxt, retry_inc;
  logic               in_rel_run;

  clk_sup_sync2 u_rst_sync  (.clk(clk_in), .rst_n(reset_n), .d(1'b1),   .q(rst_n));
  clk_sup_sync2 u_lock_sync (.clk(clk_in), .rst_n(rst_n),   .d(locked), .q(lock_s));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_HOLD;
      cnt       <= '0;
      mask      <= ALL_ON;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mask      <= mask_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  assign retry_inc = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    mask_nxt  = mask;
    retry_nxt = retry_cnt;
    case (state)
      RESET_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_nxt = retry_inc;
          cnt_nxt   = '0;
          state_nxt = (MAX_RETRY != 0 && retry_inc == RETRY_LIMIT) ? FAIL : RESET_HOLD;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
          mask_nxt  = ALL_ON << 1;
        end
      end
      RELEASE: begin
        // mask is a shifting run of ones: bit 0 drops first, empty means all released
        if (!lock_s) begin
          state_nxt = RESET_HOLD;
          cnt_nxt   = '0;
          mask_nxt  = ALL_ON;
        end else if (mask == '0) begin
          state_nxt = RUN;
          retry_nxt = '0;
          cnt_nxt   = '0;
        end else if (cnt == STAGGER_LAST) begin
          mask_nxt = mask << 1;
          cnt_nxt  = '0;
        end
      end
      RUN: begin
        cnt_nxt = cnt;
        if (!lock_s) begin
          state_nxt = RESET_HOLD;
          cnt_nxt   = '0;
          mask_nxt  = ALL_ON;
        end
      end
      FAIL: begin
        cnt_nxt = cnt;
        if (retry_req) begin
          state_nxt = RESET_HOLD;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = RESET_HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Lock loss overrides the released pattern in the same cycle lock_s falls.
  assign in_rel_run = (state == RELEASE) || (state == RUN);
  assign rst_out    = (in_rel_run && lock_s) ? mask : ALL_ON;
  assign all_ready  = (state == RUN) && lock_s;
  assign pll_rst    = (state == RESET_HOLD) || (state == FAIL);
  assign fail       = (state == FAIL);
  assign state_o    = state;

`ifdef CLK_SUP_LOSS_CNT_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (in_rel_run && !lock_s && loss_cnt != '1) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Bench for clk_lock_supervisor: a retry-limited and a retry-forever instance on shared inputs.
module tb_clk_lock_supervisor;
  localparam int N  = 3;
  localparam int RP = 4;
  localparam int LS = 8;
  localparam int LT = 32;
  localparam int SG = 2;

  localparam int P_HOLD = 0, P_WAIT = 1, P_STAB = 2, P_REL = 3, P_RUN = 4, P_FAIL = 5;

  typedef struct packed {
    int r1; int r2; int l1; int l2; int ph; int age; int rty; int loss;
  } mdl_t;

  typedef struct packed {
    logic [16:0] a;
    logic [16:0] b;
    logic [15:0] la;
    logic [15:0] lb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n   = 1'b0;
  logic       locked    = 1'b0;
  logic       retry_req = 1'b0;

  logic       a_pll, a_rdy, a_fail, b_pll, b_rdy, b_fail;
  logic [2:0] a_rst, a_st, b_rst, b_st;
  logic [7:0] a_rty, b_rty;
  logic [15:0] a_loss, b_loss;

  clk_lock_supervisor #(.NUM_OUT(N), .RST_PULSE_CYC(RP), .LOCK_STABLE_CYC(LS),
    .LOCK_TIMEOUT_CYC(LT), .STAGGER_CYC(SG), .MAX_RETRY(2)) dut (
    .clk_in(clk), .reset_n(reset_n), .locked(locked), .retry_req(retry_req),
    .pll_rst(a_pll), .rst_out(a_rst), .all_ready(a_rdy), .fail(a_fail),
    .state_o(a_st), .retry_cnt(a_rty)
`ifdef CLK_SUP_LOSS_CNT_EN
    , .loss_cnt(a_loss)
`endif
  );

  clk_lock_supervisor #(.NUM_OUT(N), .RST_PULSE_CYC(RP), .LOCK_STABLE_CYC(LS),
    .LOCK_TIMEOUT_CYC(LT), .STAGGER_CYC(SG), .MAX_RETRY(0)) dutf (
    .clk_in(clk), .reset_n(reset_n), .locked(locked), .retry_req(retry_req),
    .pll_rst(b_pll), .rst_out(b_rst), .all_ready(b_rdy), .fail(b_fail),
    .state_o(b_st), .retry_cnt(b_rty)
`ifdef CLK_SUP_LOSS_CNT_EN
    , .loss_cnt(b_loss)
`endif
  );

`ifndef CLK_SUP_LOSS_CNT_EN
  assign a_loss = '0;
  assign b_loss = '0;
`endif

  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  mdl_t ma, mb;
  exp_t sb[$];
  exp_t e;

  function automatic mdl_t mreset();
    mdl_t m;
    m = '0;
    m.ph = P_HOLD;
    return m;
  endfunction

  // Advance the reference one clock edge using the inputs held during the cycle that just ended.
  function automatic mdl_t tick(input mdl_t m, input logic rn, input logic lk,
                                input logic rq, input int maxr);
    mdl_t n;
    logic ls;
    if (!rn) return mreset();
    n = m;
    n.r1 = 1;
    n.r2 = m.r1;
    if (m.r2 == 0) return n;
    ls   = (m.l2 != 0);
    n.l1 = lk ? 1 : 0;
    n.l2 = m.l1;
    n.age = m.age + 1;
    case (m.ph)
      P_HOLD: if (n.age == RP) begin n.ph = P_WAIT; n.age = 0; end
      P_WAIT: begin
        if (ls) begin n.ph = P_STAB; n.age = 0; end
        else if (n.age == LT) begin
          n.rty = (m.rty >= 255) ? 255 : m.rty + 1;
          n.ph  = (maxr != 0 && n.rty == maxr) ? P_FAIL : P_HOLD;
          n.age = 0;
        end
      end
      P_STAB: begin
        if (!ls) begin n.ph = P_WAIT; n.age = 0; end
        else if (n.age == LS) begin n.ph = P_REL; n.age = 0; end
      end
      P_REL: begin
        if (!ls) begin n.ph = P_HOLD; n.age = 0; n.loss = (m.loss >= 65535) ? 65535 : m.loss + 1; end
        else if (n.age == (N - 1) * SG + 1) begin n.ph = P_RUN; n.age = 0; n.rty = 0; end
      end
      P_RUN: if (!ls) begin n.ph = P_HOLD; n.age = 0; n.loss = (m.loss >= 65535) ? 65535 : m.loss + 1; end
      default: if (rq) begin n.ph = P_HOLD; n.age = 0; n.rty = 0; end
    endcase
    return n;
  endfunction

  function automatic logic [16:0] mout(input mdl_t m);
    int          rel;
    logic        ls;
    logic [31:0] t;
    ls  = (m.l2 != 0);
    rel = 0;
    if (ls && m.ph == P_REL) rel = (m.age / SG + 1 > N) ? N : m.age / SG + 1;
    if (ls && m.ph == P_RUN) rel = N;
    t = 32'h7 << rel;
    return {(m.ph == P_HOLD || m.ph == P_FAIL), t[2:0], (ls && m.ph == P_RUN),
            (m.ph == P_FAIL), 3'(m.ph), 8'(m.rty)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, ncyc, act, expv);
    end
  endtask

  task automatic cyc(input logic rn, input logic lk, input logic rq);
    exp_t x;
    @(posedge clk);
    ma = tick(ma, reset_n, locked, retry_req, 2);
    mb = tick(mb, reset_n, locked, retry_req, 0);
    #1;
    reset_n   = rn;
    locked    = lk;
    retry_req = rq;
    if (!rn) begin
      ma = mreset();
      mb = mreset();
    end
    ncyc++;
    x.a  = mout(ma);
    x.b  = mout(mb);
    x.la = 16'(ma.loss);
    x.lb = 16'(mb.loss);
    sb.push_back(x);
  endtask

  task automatic wait_state(input string nm, input int st, input int budget, input logic lk);
    int i;
    i = 0;
    while (32'(a_st) != st && i < budget) begin
      cyc(1'b1, lk, 1'b0);
      i++;
    end
    chk(nm, 32'(a_st), 32'(st));
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks += 2;
      if ({a_pll, a_rst, a_rdy, a_fail, a_st, a_rty} !== e.a) begin
        errors++;
        $display("FAIL sb_lim cyc=%0d actual=%h required=%h", ncyc,
                 {a_pll, a_rst, a_rdy, a_fail, a_st, a_rty}, e.a);
      end
      if ({b_pll, b_rst, b_rdy, b_fail, b_st, b_rty} !== e.b) begin
        errors++;
        $display("FAIL sb_inf cyc=%0d actual=%h required=%h", ncyc,
                 {b_pll, b_rst, b_rdy, b_fail, b_st, b_rty}, e.b);
      end
`ifdef CLK_SUP_LOSS_CNT_EN
      checks += 2;
      if (a_loss !== e.la) begin
        errors++;
        $display("FAIL sb_loss_lim cyc=%0d actual=%0d required=%0d", ncyc, a_loss, e.la);
      end
      if (b_loss !== e.lb) begin
        errors++;
        $display("FAIL sb_loss_inf cyc=%0d actual=%0d required=%0d", ncyc, b_loss, e.lb);
      end
`endif
    end
  end

  initial begin
    ma = mreset();
    mb = mreset();

    // Power-up, lock appears at cycle 10 after reset release
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("reset_pll", 32'(a_pll), 1);
    chk("reset_rst", 32'(a_rst), 7);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
    wait_state("t1_run", P_RUN, 200, 1'b1);
    chk("t1_ready", 32'(a_rdy), 1);
    chk("t1_rst", 32'(a_rst), 0);
    chk("t1_retry", 32'(a_rty), 0);
    repeat (10) cyc(1'b1, 1'b1, 1'b0);

    // Lock loss in RUN
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("t4_rst_all", 32'(a_rst), 7);
    chk("t4_ready", 32'(a_rdy), 0);
    wait_state("t4_rerun", P_RUN, 200, 1'b1);
`ifdef CLK_SUP_LOSS_CNT_EN
    chk("t4_loss", 32'(a_loss), 1);
`endif

    // Lock loss while bit 1 is released
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    wait_state("t5_rel", P_REL, 200, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t5_partial", 32'(a_rst), 4);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t5_reassert", 32'(a_rst), 7);
    wait_state("t5_rerun", P_RUN, 200, 1'b1);

    // One-cycle glitch at STABLE count 5
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    wait_state("t3_stab", P_STAB, 200, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t3_still_stab", 32'(a_st), P_STAB);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t3_back_wait", 32'(a_st), P_WAIT);
    repeat (8) cyc(1'b1, 1'b1, 1'b0);
    chk("t3_window_open", 32'(a_st), P_STAB);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t3_window_done", 32'(a_st), P_REL);
    chk("t3_retry", 32'(a_rty), 0);
    wait_state("t3_run", P_RUN, 200, 1'b1);

    // Lock never arrives
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    wait_state("t2_fail", P_FAIL, 300, 1'b0);
    chk("t2_retry", 32'(a_rty), 2);
    chk("t2_fail_o", 32'(a_fail), 1);
    chk("t2_pll", 32'(a_pll), 1);
    chk("t2_inf_nofail", 32'(b_fail), 0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t2_rehold", 32'(a_st), P_HOLD);
    chk("t2_retry_clr", 32'(a_rty), 0);

    // Asynchronous reset mid-RELEASE
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    wait_state("t6_rel", P_REL, 200, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_pll", 32'(a_pll), 1);
    chk("t6_async_rst", 32'(a_rst), 7);
    chk("t6_async_state", 32'(a_st), P_HOLD);
    chk("t6_async_ready", 32'(a_rdy), 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Randomised lock activity, retries and resets
    for (int it = 0; it < 80; it++) begin
      int   dur;
      logic lk;
      dur = $urandom_range(60, 1);
      lk  = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) repeat (2) cyc(1'b0, lk, 1'b0);
      for (int k = 0; k < dur; k++) cyc(1'b1, lk, ($urandom_range(24, 0) == 0));
    end

    // Retry-forever instance saturates its counter
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    repeat (9600) cyc(1'b1, 1'b0, 1'b0);
    chk("t6_inf_retry", 32'(b_rty), 255);
    chk("t6_inf_fail", 32'(b_fail), 0);
    chk("t6_lim_fail", 32'(a_fail), 1);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
